// File: rtl/phase_countdown_timer.sv
// Loadable phase down-counter driven by a 1 Hz tick, with reload register,
// one-shot/auto-reload expiry, hold/restart/abort and a saturating BCD image.
module phase_countdown_timer #(
  parameter int unsigned pWIDTH       = 7,
  parameter int unsigned pDEFAULT_VAL = 99,
  parameter int unsigned pPRE_LAST    = 1,
  parameter int unsigned pAUTO_RELOAD = 1,
  parameter int unsigned pBCD_DIGITS  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     hold,
  input  logic                     load,
  input  logic [pWIDTH-1:0]        load_val,
  output logic [pWIDTH-1:0]        count,
  output logic [4*pBCD_DIGITS-1:0] bcd,
  output logic                     busy,
  output logic                     last,
  output logic                     pre_last,
  output logic                     done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [pWIDTH-1:0] DEFAULT_VAL = pWIDTH'(pDEFAULT_VAL);
  localparam logic [pWIDTH-1:0] PRE_LAST    = pWIDTH'(pPRE_LAST);
  localparam int unsigned       BCD_W       = 4 * pBCD_DIGITS;
  localparam int unsigned       BCD_MAX     = 10**pBCD_DIGITS - 1;

  state_t              state_q, state_d;
  logic [pWIDTH-1:0]   reload_q, reload_d;
  logic [pWIDTH-1:0]   count_q, count_d;
  logic                done_q, done_d;
  logic [pWIDTH-1:0]   reload_val;
  logic [BCD_W-1:0]    bcd_work;

  // A load in the same cycle as a (re)start or reload takes effect immediately.
  assign reload_val = load ? load_val : reload_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      reload_q <= DEFAULT_VAL;
      count_q  <= DEFAULT_VAL;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_val;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          count_d = reload_val;
        end else if (load) begin
          count_d = load_val;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          count_d = reload_val;
        end else if (start) begin
          count_d = reload_val;
        end else if (!hold && tick) begin
          if (count_q != '0) begin
            count_d = count_q - pWIDTH'(1);
          end else begin
            done_d = 1'b1;
            if (pAUTO_RELOAD != 0) count_d = reload_val;
            else                   state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Double dabble; digits above the display range are handled by saturation.
  always_comb begin
    bcd_work = '0;
    for (int unsigned i = 0; i < pWIDTH; i++) begin
      for (int unsigned d = 0; d < pBCD_DIGITS; d++) begin
        if (bcd_work[4*d +: 4] >= 4'd5) bcd_work[4*d +: 4] = bcd_work[4*d +: 4] + 4'd3;
      end
      bcd_work = {bcd_work[BCD_W-2:0], count_q[pWIDTH-1-i]};
    end
    if (32'(count_q) > BCD_MAX) bcd_work = {pBCD_DIGITS{4'h9}};
  end

  assign bcd      = bcd_work;
  assign count    = count_q;
  assign busy     = (state_q == RUN);
  assign last     = busy && (count_q == '0);
  assign pre_last = busy && (count_q == PRE_LAST);
  assign done     = done_q;

endmodule

// File: doc/phase_countdown_timer.md
Name: phase_countdown_timer

Overview:
Parametrised, loadable down-counter for traffic-light phase timing. It counts down on an external once-per-second tick and supports a runtime-programmable reload value, one-shot or auto-reload mode, hold (freeze), restart and abort. It provides last, pre-last and done flags plus a BCD image of the count for the 7-segment display path. It sits between the phase FSM, which issues start/stop/load, and the display decoder.

Parameters:
pWIDTH, 7, width of count, reload register and load_val.
pDEFAULT_VAL, 99, reload value after reset; must fit in pWIDTH bits.
pPRE_LAST, 1, count value at which pre_last asserts; must be >0 and <2**pWIDTH.
pAUTO_RELOAD, 1, 1 = reload and keep running at expiry; 0 = one-shot, return to IDLE.
pBCD_DIGITS, 2, number of BCD digits in bcd output.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
tick  input  1  count-enable strobe, one clk wide, nominally 1 Hz.
start  input  1  start or restart countdown.
stop  input  1  abort countdown, return to IDLE.
hold  input  1  level; freezes counting while high.
load  input  1  write load_val into reload register.
load_val  input  pWIDTH  new reload value.
count  output  pWIDTH  current count, registered.
bcd  output  4*pBCD_DIGITS  BCD of count, digit 0 in bits [3:0].
busy  output  1  high in RUN.
last  output  1  busy && count==0.
pre_last  output  1  busy && count==pPRE_LAST.
done  output  1  one-cycle pulse on expiry.

Behaviour:
- Reset (async, any state): state=IDLE; reload_reg=pDEFAULT_VAL; count=pDEFAULT_VAL; done=0; busy=0.
- States: IDLE, RUN. busy is decoded from state RUN.
- load, any state: reload_reg<=load_val on the next edge. In IDLE, count<=load_val on the same edge. In RUN, count is unaffected and the new value applies at the next reload or restart.
- Effective reload value V = load_val if load is high in the same cycle, else reload_reg.
- IDLE: stop has no effect. start -> RUN, count<=V. tick is ignored.
- RUN priority, highest first:
  - stop: -> IDLE, count<=V, no done.
  - start: restart, count<=V, stay RUN, no done.
  - hold: count frozen, tick ignored.
  - tick with count>0: count<=count-1.
  - tick with count==0: done=1 for exactly one cycle. If pAUTO_RELOAD=1, count<=V and stay RUN. If pAUTO_RELOAD=0, -> IDLE and count stays 0; last and pre_last then drop because busy=0.
- Period: each countdown lasts V+1 ticks from start to done. V=0 is legal: done fires on the first tick.
- done is registered, asserted in the cycle after the expiring tick edge, and is never asserted in IDLE except that one-cycle pulse.
- last and pre_last are combinational from registered state and count. No glitch requirement beyond that.
- bcd: combinational binary-to-BCD conversion (double dabble) of count. If count > 10**pBCD_DIGITS-1, every digit shows 9 (saturated).
- Arithmetic: count never wraps below 0. All compares are unsigned at pWIDTH.
- Reset asserted mid-count: immediate return to reset values. A previously loaded reload_reg is lost and reverts to pDEFAULT_VAL.
- hold in IDLE: no effect; start is still accepted.

Test Plan:
- Reset then start, 100 ticks with defaults: count 99->0; pre_last high at count 1; last high at 0; done pulse on the 100th tick; count=99 and busy=1 afterwards.
- pAUTO_RELOAD=0, load_val=5 with load in IDLE, then start, 6 ticks: count 5..0; done on the 6th tick; state IDLE, count=0, last=0.
- In RUN at count=40, hold high for 10 ticks: count stays 40. Release hold, then 1 tick: count=39. Same cycle as a tick, assert stop: IDLE, count=reload value, no done.
- In RUN, load_val=20 while count=3: count continues 3,2,1,0; at expiry count reloads to 20, not 99. Same-cycle load and start in IDLE with load_val=7: count=7.
- bcd check with pWIDTH=7, pBCD_DIGITS=2: count=99 -> 0x99; count=45 -> 0x45; load 120 -> bcd 0x99 (saturated).
- Assert rst asynchronously between clock edges mid-count after a load of 30: outputs go to reset values immediately; reload_reg=99; done=0.
